// File: rtl/lc2k_multicycle_ctrl.sv
// lc2k_multicycle_ctrl
//   Multicycle control FSM for the LC2K CPU. Sequences fetch, decode,
//   execute, memory access and write-back. It drives the datapath strobes
//   (PC/IR load, ALU controls, register-file write) and a req/ready
//   handshake to unified memory.
//
// Ports
//   clk, reset        clock; async active-high reset
//   start             level; leaves IDLE
//   ir_opcode[2:0]    IR[24:22] (add,nor,lw,sw,beq,jalr,halt,noop)
//   alu_zero          regA == regB compare from the datapath
//   mem_ready         memory completes the current access this cycle
//   mem_req/mem_we    memory request / write strobe
//   mem_addr_sel      0 = PC, 1 = ALU result
//   ir_write          load IR from memory read data
//   pc_write          load PC; pc_src_sel 0 = PC+1, 1 = PC+offset, 2 = regA
//   alu_op            0 = add, 1 = nor; alu_srcB_sel 0 = regB, 1 = offset
//   reg_we            register-file write enable
//   reg_dst_sel       0 = IR[2:0], 1 = IR[18:16]
//   reg_wdata_sel     0 = ALU, 1 = memory data, 2 = PC
//   halted / error    sticky HALT / memory-timeout indications
//   instr_count       retired instructions, wraps modulo 2^CNT_W
module lc2k_multicycle_ctrl #(
  parameter int CNT_W       = 32,
  parameter int MEM_TIMEOUT = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       ir_opcode,
  input  logic             alu_zero,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic             mem_addr_sel,
  output logic             ir_write,
  output logic             pc_write,
  output logic [1:0]       pc_src_sel,
  output logic             alu_op,
  output logic             alu_srcB_sel,
  output logic             reg_we,
  output logic             reg_dst_sel,
  output logic [1:0]       reg_wdata_sel,
  output logic             halted,
  output logic             error,
  output logic [CNT_W-1:0] instr_count
);

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC_R, S_ADDR, S_MEM,
    S_LW_WB, S_BEQ, S_JALR, S_HALT, S_ERR
  } state_t;

  localparam logic [2:0] OP_ADD = 3'b000, OP_NOR = 3'b001, OP_LW   = 3'b010,
                         OP_SW  = 3'b011, OP_BEQ = 3'b100, OP_JALR = 3'b101,
                         OP_HALT = 3'b110, OP_NOOP = 3'b111;

  localparam bit          TO_EN   = (MEM_TIMEOUT != 0);
  localparam logic [31:0] TO_LAST = 32'(MEM_TIMEOUT - 1);

  state_t           r_state;
  logic [CNT_W-1:0] r_count;
  logic [31:0]      r_wait;
  logic             w_timeout;

  // Last allowed waiting cycle reached with memory still not ready.
  assign w_timeout   = TO_EN && !mem_ready && (r_wait == TO_LAST);
  assign instr_count = r_count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_count <= '0;
      r_wait  <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (start) begin
          r_state <= S_FETCH;
          r_wait  <= '0;
        end
        S_FETCH: begin
          if (mem_ready)      r_state <= S_DECODE;
          else if (w_timeout) r_state <= S_ERR;
          else                r_wait  <= r_wait + 32'd1;
        end
        S_DECODE: begin
          case (ir_opcode)
            OP_ADD, OP_NOR: r_state <= S_EXEC_R;
            OP_LW, OP_SW:   r_state <= S_ADDR;
            OP_BEQ:         r_state <= S_BEQ;
            OP_JALR:        r_state <= S_JALR;
            OP_HALT: begin
              r_state <= S_HALT;
              r_count <= r_count + CNT_W'(1);
            end
            default: begin  // noop retires straight from decode
              r_state <= S_FETCH;
              r_wait  <= '0;
              r_count <= r_count + CNT_W'(1);
            end
          endcase
        end
        S_ADDR: begin
          r_state <= S_MEM;
          r_wait  <= '0;
        end
        S_MEM: begin
          if (mem_ready) begin
            if (ir_opcode == OP_SW) begin
              r_state <= S_FETCH;
              r_wait  <= '0;
              r_count <= r_count + CNT_W'(1);
            end else begin
              r_state <= S_LW_WB;
            end
          end else if (w_timeout) begin
            r_state <= S_ERR;
          end else begin
            r_wait <= r_wait + 32'd1;
          end
        end
        S_EXEC_R, S_LW_WB, S_BEQ, S_JALR: begin
          r_state <= S_FETCH;
          r_wait  <= '0;
          r_count <= r_count + CNT_W'(1);
        end
        S_HALT:  r_state <= S_HALT;
        S_ERR:   r_state <= S_ERR;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Outputs decode the state register directly so that an async reset
  // drops mem_req immediately, even in the middle of an access.
  always_comb begin
    mem_req       = 1'b0;
    mem_we        = 1'b0;
    mem_addr_sel  = 1'b0;
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    pc_src_sel    = 2'd0;
    alu_op        = 1'b0;
    alu_srcB_sel  = 1'b0;
    reg_we        = 1'b0;
    reg_dst_sel   = 1'b0;
    reg_wdata_sel = 2'd0;
    halted        = 1'b0;
    error         = 1'b0;
    case (r_state)
      S_FETCH: begin
        mem_req  = 1'b1;
        ir_write = mem_ready;
        pc_write = mem_ready;
      end
      S_EXEC_R: begin
        alu_op = ir_opcode[0];
        reg_we = 1'b1;
      end
      S_ADDR: alu_srcB_sel = 1'b1;
      S_MEM: begin
        mem_req      = 1'b1;
        mem_addr_sel = 1'b1;
        mem_we       = (ir_opcode == OP_SW);
      end
      S_LW_WB: begin
        reg_we        = 1'b1;
        reg_dst_sel   = 1'b1;
        reg_wdata_sel = 2'd1;
      end
      // PC already holds PC+1, so PC+offset lands on PC+1+offset.
      S_BEQ: begin
        pc_write   = alu_zero;
        pc_src_sel = 2'd1;
      end
      // regA is read combinationally, so the PC gets the old regA value
      // even when the link write targets the same register.
      S_JALR: begin
        reg_we        = 1'b1;
        reg_dst_sel   = 1'b1;
        reg_wdata_sel = 2'd2;
        pc_write      = 1'b1;
        pc_src_sel    = 2'd2;
      end
      S_HALT:  halted = 1'b1;
      S_ERR:   error  = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_lc2k_multicycle_ctrl.sv
module tb_lc2k_multicycle_ctrl;
  logic        clk = 1'b0, reset = 1'b1, start = 1'b0;
  logic        alu_zero = 1'b0, mem_ready = 1'b0;
  logic [2:0]  ir_opcode = 3'd0;
  logic        mem_req, mem_we, mem_addr_sel, ir_write, pc_write;
  logic [1:0]  pc_src_sel, reg_wdata_sel;
  logic        alu_op, alu_srcB_sel, reg_we, reg_dst_sel, halted, error;
  logic [31:0] instr_count;
  int checks = 0, errors = 0;

  // Control vector: {mem_req, mem_we, mem_addr_sel, ir_write, pc_write,
  //   pc_src_sel[1:0], alu_op, alu_srcB_sel, reg_we, reg_dst_sel,
  //   reg_wdata_sel[1:0], halted, error}
  wire [14:0] outv = {mem_req, mem_we, mem_addr_sel, ir_write, pc_write,
                      pc_src_sel, alu_op, alu_srcB_sel, reg_we, reg_dst_sel,
                      reg_wdata_sel, halted, error};

  localparam logic [14:0] E_NONE = 15'h0000, E_FWAIT = 15'h4000,
    E_FRDY = 15'h4C00, E_ADD = 15'h0020, E_NOR = 15'h00A0, E_ADDR = 15'h0040,
    E_MLW = 15'h5000, E_MSW = 15'h7000, E_LWWB = 15'h0034,
    E_BEQT = 15'h0500, E_BEQN = 15'h0100, E_JALR = 15'h0638,
    E_HALT = 15'h0002, E_ERR = 15'h0001;

  typedef struct packed {
    logic [2:0]  op;
    logic        rdy;
    logic        z;
    logic        st;
    logic [14:0] exp;
  } step_t;

  lc2k_multicycle_ctrl #(.CNT_W(32), .MEM_TIMEOUT(4)) dut (
    .clk(clk), .reset(reset), .start(start), .ir_opcode(ir_opcode),
    .alu_zero(alu_zero), .mem_ready(mem_ready), .mem_req(mem_req),
    .mem_we(mem_we), .mem_addr_sel(mem_addr_sel), .ir_write(ir_write),
    .pc_write(pc_write), .pc_src_sel(pc_src_sel), .alu_op(alu_op),
    .alu_srcB_sel(alu_srcB_sel), .reg_we(reg_we), .reg_dst_sel(reg_dst_sel),
    .reg_wdata_sel(reg_wdata_sel), .halted(halted), .error(error),
    .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  function automatic step_t mk(input logic [2:0] op, input logic rdy,
                               input logic z, input logic st,
                               input logic [14:0] exp);
    step_t s;
    s.op = op; s.rdy = rdy; s.z = z; s.st = st; s.exp = exp;
    return s;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply(input step_t s);
    ir_opcode = s.op; mem_ready = s.rdy; alu_zero = s.z; start = s.st;
    #1;
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if (outv !== E_NONE) begin errors++; $display("FAIL reset_outputs got %h want %h", outv, E_NONE); end
    checks++;
    if (instr_count !== 32'd0) begin errors++; $display("FAIL reset_count got %0d want 0", instr_count); end
    tick();
    reset = 1'b0;
  endtask

  task automatic test_add_nor();
    step_t q[$];
    q.push_back(mk(3'b000, 1'b1, 1'b0, 1'b1, E_NONE));   // IDLE, start
    q.push_back(mk(3'b000, 1'b1, 1'b0, 1'b0, E_FRDY));   // FETCH add
    q.push_back(mk(3'b000, 1'b1, 1'b0, 1'b0, E_NONE));   // DECODE
    q.push_back(mk(3'b000, 1'b1, 1'b0, 1'b0, E_ADD));    // EXEC_R
    q.push_back(mk(3'b001, 1'b1, 1'b0, 1'b0, E_FRDY));   // FETCH nor
    q.push_back(mk(3'b001, 1'b1, 1'b0, 1'b0, E_NONE));
    q.push_back(mk(3'b001, 1'b1, 1'b0, 1'b0, E_NOR));
    foreach (q[i]) begin
      apply(q[i]);
      checks++;
      if (outv !== q[i].exp) begin errors++; $display("FAIL add_nor step %0d ctrl got %h want %h", i, outv, q[i].exp); end
      tick();
    end
    checks++;
    if (instr_count !== 32'd2) begin errors++; $display("FAIL add_nor_count got %0d want 2", instr_count); end
  endtask

  task automatic test_lw_wait();
    step_t q[$];
    q.push_back(mk(3'b010, 1'b1, 1'b0, 1'b0, E_FRDY));
    q.push_back(mk(3'b010, 1'b1, 1'b0, 1'b0, E_NONE));
    q.push_back(mk(3'b010, 1'b1, 1'b0, 1'b0, E_ADDR));
    q.push_back(mk(3'b010, 1'b0, 1'b0, 1'b0, E_MLW));    // MEM, 3 waits
    q.push_back(mk(3'b010, 1'b0, 1'b0, 1'b0, E_MLW));
    q.push_back(mk(3'b010, 1'b0, 1'b0, 1'b0, E_MLW));
    q.push_back(mk(3'b010, 1'b1, 1'b0, 1'b0, E_MLW));    // 4th cycle: ready
    q.push_back(mk(3'b010, 1'b0, 1'b0, 1'b0, E_LWWB));
    foreach (q[i]) begin
      apply(q[i]);
      checks++;
      if (outv !== q[i].exp) begin errors++; $display("FAIL lw step %0d ctrl got %h want %h", i, outv, q[i].exp); end
      tick();
    end
    checks++;
    if (instr_count !== 32'd3) begin errors++; $display("FAIL lw_count got %0d want 3", instr_count); end
  endtask

  task automatic test_sw_beq();
    step_t q[$];
    q.push_back(mk(3'b011, 1'b1, 1'b0, 1'b0, E_FRDY));
    q.push_back(mk(3'b011, 1'b1, 1'b0, 1'b0, E_NONE));
    q.push_back(mk(3'b011, 1'b1, 1'b0, 1'b0, E_ADDR));
    q.push_back(mk(3'b011, 1'b1, 1'b0, 1'b0, E_MSW));
    q.push_back(mk(3'b100, 1'b1, 1'b1, 1'b0, E_FRDY));
    q.push_back(mk(3'b100, 1'b1, 1'b1, 1'b0, E_NONE));
    q.push_back(mk(3'b100, 1'b1, 1'b1, 1'b0, E_BEQT));
    q.push_back(mk(3'b100, 1'b1, 1'b0, 1'b0, E_FRDY));
    q.push_back(mk(3'b100, 1'b1, 1'b0, 1'b0, E_NONE));
    q.push_back(mk(3'b100, 1'b1, 1'b0, 1'b0, E_BEQN));
    foreach (q[i]) begin
      apply(q[i]);
      checks++;
      if (outv !== q[i].exp) begin errors++; $display("FAIL sw_beq step %0d ctrl got %h want %h", i, outv, q[i].exp); end
      tick();
    end
    checks++;
    if (instr_count !== 32'd6) begin errors++; $display("FAIL sw_beq_count got %0d want 6", instr_count); end
  endtask

  task automatic test_jalr_halt();
    step_t q[$];
    q.push_back(mk(3'b101, 1'b1, 1'b1, 1'b0, E_FRDY));
    q.push_back(mk(3'b101, 1'b1, 1'b1, 1'b0, E_NONE));
    q.push_back(mk(3'b101, 1'b1, 1'b1, 1'b0, E_JALR));
    q.push_back(mk(3'b110, 1'b1, 1'b0, 1'b0, E_FRDY));
    q.push_back(mk(3'b110, 1'b1, 1'b0, 1'b0, E_NONE));
    q.push_back(mk(3'b110, 1'b1, 1'b0, 1'b0, E_HALT));
    q.push_back(mk(3'b110, 1'b1, 1'b0, 1'b1, E_HALT));   // start ignored
    q.push_back(mk(3'b110, 1'b1, 1'b0, 1'b0, E_HALT));
    q.push_back(mk(3'b000, 1'b1, 1'b0, 1'b1, E_HALT));
    foreach (q[i]) begin
      apply(q[i]);
      checks++;
      if (outv !== q[i].exp) begin errors++; $display("FAIL jalr_halt step %0d ctrl got %h want %h", i, outv, q[i].exp); end
      tick();
    end
    checks++;
    if (instr_count !== 32'd8) begin errors++; $display("FAIL jalr_halt_count got %0d want 8", instr_count); end
  endtask

  task automatic test_timeout();
    step_t q[$];
    start = 1'b0; reset = 1'b1;
    #1;
    checks++;
    if (outv !== E_NONE || instr_count !== 32'd0) begin
      errors++; $display("FAIL to_reset ctrl got %h cnt %0d want %h cnt 0", outv, instr_count, E_NONE);
    end
    tick();
    reset = 1'b0;
    q.push_back(mk(3'b000, 1'b0, 1'b0, 1'b1, E_NONE));
    q.push_back(mk(3'b000, 1'b0, 1'b0, 1'b0, E_FWAIT));
    q.push_back(mk(3'b000, 1'b0, 1'b0, 1'b0, E_FWAIT));
    q.push_back(mk(3'b000, 1'b0, 1'b0, 1'b0, E_FWAIT));
    q.push_back(mk(3'b000, 1'b0, 1'b0, 1'b0, E_FWAIT));
    q.push_back(mk(3'b000, 1'b0, 1'b0, 1'b0, E_ERR));
    q.push_back(mk(3'b000, 1'b1, 1'b0, 1'b0, E_ERR));
    q.push_back(mk(3'b000, 1'b1, 1'b0, 1'b1, E_ERR));
    foreach (q[i]) begin
      apply(q[i]);
      checks++;
      if (outv !== q[i].exp) begin errors++; $display("FAIL timeout step %0d ctrl got %h want %h", i, outv, q[i].exp); end
      tick();
    end
  endtask

  task automatic test_reset_mid_mem();
    step_t q[$];
    step_t r[$];
    start = 1'b0; reset = 1'b1;
    tick();
    reset = 1'b0;
    q.push_back(mk(3'b111, 1'b1, 1'b0, 1'b1, E_NONE));
    q.push_back(mk(3'b111, 1'b1, 1'b0, 1'b0, E_FRDY));   // noop
    q.push_back(mk(3'b111, 1'b1, 1'b0, 1'b0, E_NONE));
    q.push_back(mk(3'b010, 1'b1, 1'b0, 1'b0, E_FRDY));   // lw
    q.push_back(mk(3'b010, 1'b1, 1'b0, 1'b0, E_NONE));
    q.push_back(mk(3'b010, 1'b1, 1'b0, 1'b0, E_ADDR));
    q.push_back(mk(3'b010, 1'b0, 1'b0, 1'b0, E_MLW));
    q.push_back(mk(3'b010, 1'b0, 1'b0, 1'b0, E_MLW));
    foreach (q[i]) begin
      apply(q[i]);
      checks++;
      if (outv !== q[i].exp) begin errors++; $display("FAIL midmem step %0d ctrl got %h want %h", i, outv, q[i].exp); end
      if (i < q.size() - 1) tick();
    end
    checks++;
    if (instr_count !== 32'd1) begin errors++; $display("FAIL midmem_count got %0d want 1", instr_count); end
    reset = 1'b1;   // mid-cycle, well before the next edge
    #1;
    checks++;
    if (mem_req !== 1'b0 || outv !== E_NONE) begin
      errors++; $display("FAIL midmem_async ctrl got %h want %h", outv, E_NONE);
    end
    checks++;
    if (instr_count !== 32'd0) begin errors++; $display("FAIL midmem_rst_count got %0d want 0", instr_count); end
    tick();
    reset = 1'b0;
    r.push_back(mk(3'b000, 1'b0, 1'b0, 1'b1, E_NONE));
    r.push_back(mk(3'b000, 1'b0, 1'b0, 1'b0, E_FWAIT));
    r.push_back(mk(3'b000, 1'b1, 1'b0, 1'b0, E_FRDY));
    r.push_back(mk(3'b000, 1'b1, 1'b0, 1'b0, E_NONE));
    foreach (r[i]) begin
      apply(r[i]);
      checks++;
      if (outv !== r[i].exp) begin errors++; $display("FAIL refetch step %0d ctrl got %h want %h", i, outv, r[i].exp); end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_add_nor();
    test_lw_wait();
    test_sw_beq();
    test_jalr_halt();
    test_timeout();
    test_reset_mid_mem();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
